// File: rtl/alu_dispatch_if.sv
// Request/response bundle for alu_dispatch: start/op/operands in, handshake plus result and flags out.
interface alu_dispatch_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             err;

  modport master (
    output start, op, a, b,
    input  ready, done, result_hi, result_lo, carry, overflow, zero, err
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, result_hi, result_lo, carry, overflow, zero, err
  );
endinterface

// File: rtl/alu_dispatch.sv
// Multi-cycle ADD/SUB/MUL/NEG unit with start/ready/done handshake and registered flags.
// Define ALU_DISPATCH_MUL_EN to build the sequential radix-2 Booth multiplier.
module alu_dispatch #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_dispatch_if.slave bus_io
);

  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpSub = 2'd1;
  localparam logic [1:0] OpMul = 2'd2;
  localparam logic [1:0] OpNeg = 2'd3;

  localparam logic [WIDTH-1:0] MinNeg = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StMulIter} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             err_q;

  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  logic             calc_carry;
  logic             calc_ovf;
  logic             calc_err;
  logic [WIDTH:0]   sum;

`ifdef ALU_DISPATCH_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // One guard bit on the accumulator keeps A +/- M exact even for M = most-negative.
  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH-1:0] mq_q;
  logic             qm1_q;
  logic [CntW-1:0]  cnt_q;
  logic             booth_last;

  assign m_ext      = {a_q[WIDTH-1], a_q};
  assign booth_last = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    booth_sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
  end
`endif

  always_comb begin
    calc_hi    = '0;
    calc_lo    = '0;
    calc_carry = 1'b0;
    calc_ovf   = 1'b0;
    calc_err   = 1'b0;
    sum        = '0;
    case (op_q)
      OpAdd: begin
        sum        = {1'b0, a_q} + {1'b0, b_q};
        calc_lo    = sum[WIDTH-1:0];
        calc_carry = sum[WIDTH];
        calc_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        sum        = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH + 1)'(1);
        calc_lo    = sum[WIDTH-1:0];
        calc_carry = sum[WIDTH];
        calc_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpNeg: begin
        calc_lo  = ~a_q + WIDTH'(1);
        calc_ovf = (a_q == MinNeg);
      end
      OpMul: begin
`ifdef ALU_DISPATCH_MUL_EN
        calc_hi  = acc_q[WIDTH-1:0];
        calc_lo  = mq_q;
        // Product fits in WIDTH bits only if hi is pure sign extension of lo.
        calc_ovf = (acc_q[WIDTH-1:0] != {WIDTH{mq_q[WIDTH-1]}});
`else
        calc_err = 1'b1;
`endif
      end
      default: calc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
`ifdef ALU_DISPATCH_MUL_EN
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus_io.start) begin
            op_q    <= bus_io.op;
            a_q     <= bus_io.a;
            b_q     <= bus_io.b;
            ready_q <= 1'b0;
`ifdef ALU_DISPATCH_MUL_EN
            if (bus_io.op == OpMul) begin
              state_q <= StMulIter;
              acc_q   <= '0;
              mq_q    <= bus_io.b;
              qm1_q   <= 1'b0;
              cnt_q   <= '0;
            end else begin
              state_q <= StCalc;
            end
`else
            state_q <= StCalc;
`endif
          end
        end
        StMulIter: begin
`ifdef ALU_DISPATCH_MUL_EN
          // Arithmetic shift right of {A, Q, q-1} after the add/sub step.
          acc_q <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          mq_q  <= {booth_sum[0], mq_q[WIDTH-1:1]};
          qm1_q <= mq_q[0];
          cnt_q <= cnt_q + CntW'(1);
          if (booth_last) begin
            state_q <= StCalc;
          end
`else
          state_q <= StIdle;
          ready_q <= 1'b1;
`endif
        end
        StCalc: begin
          hi_q    <= calc_hi;
          lo_q    <= calc_lo;
          carry_q <= calc_carry;
          ovf_q   <= calc_ovf;
          err_q   <= calc_err;
          zero_q  <= ({calc_hi, calc_lo} == '0);
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.ready     = ready_q;
  assign bus_io.done      = done_q;
  assign bus_io.result_hi = hi_q;
  assign bus_io.result_lo = lo_q;
  assign bus_io.carry     = carry_q;
  assign bus_io.overflow  = ovf_q;
  assign bus_io.zero      = zero_q;
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: WIDTH=8 instance driven with directed and random ops,
// plus a WIDTH=16 instance for one wide multiply.
module tb_alu_dispatch;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] last_hi = '0;
  logic [7:0] last_lo = '0;

  alu_dispatch_if #(.WIDTH(8))  b8 ();
  alu_dispatch_if #(.WIDTH(16)) b16 ();

  alu_dispatch #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (b8)
  );

  alu_dispatch #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (b16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int latency(input logic [1:0] op);
`ifdef ALU_DISPATCH_MUL_EN
    return (op == 2'd2) ? 9 : 1;
`else
    return 1;
`endif
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb_v, u, s, p;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb_v = $signed(b);
    e.hi = '0; e.lo = '0; e.carry = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.cyc = 0;
    case (op)
      2'd0: begin
        u = ua + ub; s = sa + sb_v;
        e.lo = 8'(u); e.carry = (u > 255); e.ovf = (s > 127) || (s < -128);
      end
      2'd1: begin
        u = ua + (255 - ub) + 1; s = sa - sb_v;
        e.lo = 8'(u); e.carry = (u > 255); e.ovf = (s > 127) || (s < -128);
      end
      2'd2: begin
`ifdef ALU_DISPATCH_MUL_EN
        p = sa * sb_v;
        {e.hi, e.lo} = 16'(p);
        e.ovf = (p > 127) || (p < -128);
`else
        e.err = 1'b1;
`endif
      end
      default: begin
        s = -sa;
        e.lo = 8'(0 - ua); e.ovf = (s > 127);
      end
    endcase
    e.zero = ({e.hi, e.lo} == 16'h0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   waited = 0;
    while (!b8.ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ready_before_issue", b8.ready, 1);
    e     = model(op, a, b);
    e.cyc = cyc + 1 + latency(op);
    sb.push_back(e);
    b8.op    = op;
    b8.a     = a;
    b8.b     = b;
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    // Scramble operands after accept; the unit must ignore them.
    b8.op    = 2'($urandom);
    b8.a     = 8'($urandom);
    b8.b     = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_pending", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && b8.done) begin
      check_eq("pending_at_done", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("done_cycle", cyc, mon_e.cyc);
        check_eq("result_lo", b8.result_lo, mon_e.lo);
        check_eq("result_hi", b8.result_hi, mon_e.hi);
        check_eq("carry", b8.carry, mon_e.carry);
        check_eq("overflow", b8.overflow, mon_e.ovf);
        check_eq("zero", b8.zero, mon_e.zero);
        check_eq("err", b8.err, mon_e.err);
        check_eq("ready_at_done", b8.ready, 1);
        last_hi = mon_e.hi;
        last_lo = mon_e.lo;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    int k;
    b8.start = 1'b0;  b8.op = 2'd0;  b8.a = '0;  b8.b = '0;
    b16.start = 1'b0; b16.op = 2'd0; b16.a = '0; b16.b = '0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_ready", b8.ready, 1);
    check_eq("rst_done", b8.done, 0);
    check_eq("rst_hilo", {b8.result_hi, b8.result_lo}, 0);
    check_eq("rst_flags", {b8.carry, b8.overflow, b8.zero, b8.err}, 4'b0010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd0, 8'd200, 8'd100);
    issue(2'd1, 8'd5, 8'd7);
    issue(2'd1, 8'h80, 8'h01);
    issue(2'd3, 8'h80, 8'h00);
    issue(2'd3, 8'h00, 8'h55);
    issue(2'd2, 8'hFD, 8'h05);
    issue(2'd2, 8'h80, 8'h80);
    for (int i = 0; i < 12; i++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    drain();

`ifdef ALU_DISPATCH_MUL_EN
    // A start while busy must be dropped; no extra done and the result holds afterwards.
    issue(2'd2, 8'h07, 8'hF9);
    repeat (2) @(negedge clk);
    b8.op = 2'd0; b8.a = 8'd1; b8.b = 8'd1; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    check_eq("hold_lo", b8.result_lo, last_lo);
    check_eq("hold_hi", b8.result_hi, last_hi);
`endif

    // Async reset in the middle of a multiply; the aborted op never completes.
    issue(2'd2, 8'h80, 8'h80);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check_eq("midrst_ready", b8.ready, 1);
    check_eq("midrst_done", b8.done, 0);
    check_eq("midrst_hilo", {b8.result_hi, b8.result_lo}, 0);
    check_eq("midrst_flags", {b8.carry, b8.overflow, b8.zero, b8.err}, 4'b0010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("post_rst_idle_hilo", {b8.result_hi, b8.result_lo}, 0);
    issue(2'd0, 8'd1, 8'd1);
    issue(2'd2, 8'h03, 8'h04);
    issue(2'd0, 8'd1, 8'd1);
    drain();

    // Wide instance: 300 * -2.
    @(negedge clk);
    b16.op = 2'd2; b16.a = 16'd300; b16.b = 16'hFFFE; b16.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    b16.start = 1'b0;
    k = 0;
    while (!b16.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("w16_done_seen", b16.done, 1);
`ifdef ALU_DISPATCH_MUL_EN
    check_eq("w16_done_cycle", cyc, e0 + 17);
    check_eq("w16_product", {b16.result_hi, b16.result_lo}, 32'hFFFF_FDA8);
    check_eq("w16_err", b16.err, 0);
`else
    check_eq("w16_done_cycle", cyc, e0 + 1);
    check_eq("w16_product", {b16.result_hi, b16.result_lo}, 32'h0);
    check_eq("w16_err", b16.err, 1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
